// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel-word FIFO feeding an MSB-first single-bit serial stream
// Words queue in a small FIFO; a two-state shifter streams them back-to-back with framing strobes.
module bit_stream_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_x,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic [7:0]       words_sent
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    bit_idx;
  logic             at_lsb;

  // Full blocks new words even when a pop lands on the same edge.
  assign in_ready   = !rst && (count != (PW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign at_lsb     = (state == SHIFT) && (bit_idx == '0);
  assign pop        = !fifo_empty && ((state == IDLE) || at_lsb);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // Outputs are registered with the values the shifter holds after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      ser_x      <= 1'b0;
      ser_valid  <= 1'b0;
      ser_first  <= 1'b0;
      ser_last   <= 1'b0;
      words_sent <= 8'd0;
    end else begin
      if (at_lsb) begin
        words_sent <= words_sent + 8'd1;
      end
      if (pop) begin
        state     <= SHIFT;
        shreg     <= head;
        bit_idx   <= IW'(WIDTH - 1);
        ser_x     <= head[WIDTH-1];
        ser_valid <= 1'b1;
        ser_first <= 1'b1;
        ser_last  <= 1'b0;
      end else if ((state == SHIFT) && (bit_idx != '0)) begin
        shreg     <= {shreg[WIDTH-2:0], 1'b0};
        bit_idx   <= bit_idx - 1'b1;
        ser_x     <= shreg[WIDTH-2];
        ser_valid <= 1'b1;
        ser_first <= 1'b0;
        ser_last  <= (bit_idx == IW'(1));
      end else begin
        state     <= IDLE;
        ser_x     <= 1'b0;
        ser_valid <= 1'b0;
        ser_first <= 1'b0;
        ser_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - directed self-checking bench for bit_stream_serializer
// Covers reset, single word framing, back-to-back streaming, backpressure, mid-word reset and counter wrap.
module tb_bit_stream_serializer;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ser_x;
  logic        ser_valid;
  logic        ser_first;
  logic        ser_last;
  logic [7:0]  words_sent;

  int checks;
  int errors;

  logic [15:0] acc;
  logic [15:0] words_q [$];
  int          run;
  int          max_run;

  bit_stream_serializer #(.WIDTH(16), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_x      (ser_x),
    .ser_valid  (ser_valid),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rebuilds words from the serial stream and tracks the longest valid run.
  always @(negedge clk) begin
    if (ser_valid) begin
      acc = ser_first ? {15'd0, ser_x} : {acc[14:0], ser_x};
      if (ser_last) words_q.push_back(acc);
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("push_timeout", t, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (ser_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("idle_timeout", t, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_bits;
    int          t;
    int          cnt;
    int          base;
    checks = 0;
    errors = 0;
    run = 0;
    max_run = 0;
    acc = '0;

    // 1: reset with in_valid asserted
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hDEAD;
    #6;
    check("rst_in_ready", in_ready, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_x", ser_x, 0);
    check("rst_words_sent", words_sent, 0);
    #6 rst = 1'b0;
    in_valid = 1'b0;
    #1 check("rel_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 2: single word 1E39
    push_word(16'h1E39);
    exp_bits = 16'b0001_1110_0011_1001;
    @(negedge clk);
    check("t2_idle_valid", ser_valid, 0);
    check("t2_idle_x", ser_x, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("t2_valid_%0d", i), ser_valid, 1);
      check($sformatf("t2_bit_%0d", i), ser_x, exp_bits[15-i]);
      check($sformatf("t2_first_%0d", i), ser_first, (i == 0) ? 1 : 0);
      check($sformatf("t2_last_%0d", i), ser_last, (i == 15) ? 1 : 0);
    end
    @(negedge clk);
    check("t2_drop_valid", ser_valid, 0);
    check("t2_words_sent", words_sent, 1);
    @(posedge clk); #1;

    // 3: three words back-to-back
    words_q.delete();
    max_run = 0;
    base = int'(words_sent);
    push_word(16'hFFFF);
    push_word(16'h0000);
    push_word(16'hA5A5);
    check("t3_full_ready", in_ready, 0);
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("t3_ready_return", t, 15);
    wait_idle();
    check("t3_run", max_run, 48);
    check("t3_nwords", words_q.size(), 3);
    if (words_q.size() == 3) begin
      check("t3_w0", words_q[0], 16'hFFFF);
      check("t3_w1", words_q[1], 16'h0000);
      check("t3_w2", words_q[2], 16'hA5A5);
    end
    check("t3_words_sent", words_sent, base + 3);

    // 4: a fourth word offered while full is held, then follows directly
    words_q.delete();
    max_run = 0;
    base = int'(words_sent);
    push_word(16'hFFFF);
    push_word(16'h0000);
    push_word(16'hA5A5);
    check("t4_full_ready", in_ready, 0);
    push_word(16'h5A0F);
    wait_idle();
    check("t4_run", max_run, 64);
    check("t4_nwords", words_q.size(), 4);
    if (words_q.size() == 4) begin
      check("t4_w2", words_q[2], 16'hA5A5);
      check("t4_w3", words_q[3], 16'h5A0F);
    end
    check("t4_words_sent", words_sent, base + 4);

    // 5: reset after 7 bits of 1E39
    do_reset();
    check("t5_pre_words", words_sent, 0);
    push_word(16'h1E39);
    repeat (8) @(negedge clk);
    check("t5_mid_valid", ser_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", ser_valid, 0);
    check("t5_rst_x", ser_x, 0);
    check("t5_rst_words", words_sent, 0);
    check("t5_rst_ready", in_ready, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    words_q.delete();
    push_word(16'h8001);
    @(negedge clk);
    check("t5_idle_valid", ser_valid, 0);
    @(negedge clk);
    check("t5_msb", ser_x, 1);
    check("t5_first", ser_first, 1);
    wait_idle();
    check("t5_nwords", words_q.size(), 1);
    if (words_q.size() == 1) check("t5_word", words_q[0], 16'h8001);
    check("t5_words_sent", words_sent, 1);

    // 6: words_sent wraps after 256 words
    do_reset();
    fork
      begin
        for (int i = 0; i < 256; i++) push_word(16'(i * 16'h0101 + 16'h00F0));
      end
      begin
        cnt = 0;
        t = 0;
        while (cnt < 256 && t < 6000) begin
          @(negedge clk);
          t++;
          if (ser_valid && ser_last) begin
            cnt++;
            @(negedge clk);
            t++;
            if (cnt == 255) check("t6_words_255", words_sent, 255);
            if (cnt == 256) check("t6_words_wrap", words_sent, 0);
          end
        end
        if (t >= 6000) check("t6_timeout", cnt, 256);
      end
    join
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
